// File: rtl/cmp_pipe_pkg.sv
// Shared types for the pipelined magnitude comparator: the per-stage
// decision encoding and its mapping onto the three result flags.
package cmp_pipe_pkg;

  typedef enum logic [1:0] {
    UNDECIDED = 2'b00,
    A_GT      = 2'b01,
    B_GT      = 2'b10
  } decision_e;

  // Returns {a_gt, b_gt, eq}; an undecided result after the last slice means equal.
  function automatic logic [2:0] dec_to_flags(decision_e d);
    case (d)
      A_GT:    return 3'b100;
      B_GT:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/cmp_slice_stage.sv
// One comparator stage: resolves an undecided result using this stage's
// operand slice and registers the decision together with its valid bit.
module cmp_slice_stage
  import cmp_pipe_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             vld_i,
  input  decision_e        dec_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             vld_o,
  output decision_e        dec_o
);

  decision_e dec_d;
  decision_e dec_q;
  logic      vld_q;

  always_comb begin
    dec_d = dec_i;
    if (dec_i == UNDECIDED) begin
      if (a_i > b_i) begin
        dec_d = A_GT;
      end else if (a_i < b_i) begin
        dec_d = B_GT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (adv_i) begin
      vld_q <= vld_i;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_i) begin
      dec_q <= dec_d;
    end
  end

  assign vld_o = vld_q;
  assign dec_o = dec_q;

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined magnitude comparator: MSB slice first, one slice per stage,
// whole-pipe valid/ready stall, plus a saturating count of equal results.
module cmp_pipe
  import cmp_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_eq,
  output logic [CNT_W-1:0] eq_count,
  input  logic             eq_clear
);

  localparam int NUM_STAGES = (WIDTH + SLICE - 1) / SLICE;
  localparam int EXT_W      = NUM_STAGES * SLICE;

  logic             adv;
  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [SLICE-1:0] a_sl  [NUM_STAGES];
  logic [SLICE-1:0] b_sl  [NUM_STAGES];
  logic             vld_s [NUM_STAGES];
  decision_e        dec_s [NUM_STAGES];
  logic             out_vld_q;
  decision_e        out_dec_q;
  logic [2:0]       flags;
  logic [CNT_W-1:0] eq_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q;

  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  // Flipping the top bit of sign-extended operands turns a signed compare unsigned.
  always_comb begin
    a_ext = EXT_W'(a);
    b_ext = EXT_W'(b);
    if (signed_mode) begin
      a_ext = EXT_W'($signed(a));
      b_ext = EXT_W'($signed(b));
      a_ext[EXT_W-1] = ~a_ext[EXT_W-1];
      b_ext[EXT_W-1] = ~b_ext[EXT_W-1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_sl[0] = a_ext[EXT_W-1 -: SLICE];
      assign b_sl[0] = b_ext[EXT_W-1 -: SLICE];

      cmp_slice_stage #(.SLICE(SLICE)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (adv),
        .vld_i (in_valid),
        .dec_i (UNDECIDED),
        .a_i   (a_sl[0]),
        .b_i   (b_sl[0]),
        .vld_o (vld_s[0]),
        .dec_o (dec_s[0])
      );
    end else begin : g_rest
      // Slice k is delayed k cycles so it meets the decision of its own pair.
      logic [SLICE-1:0] a_dq [k];
      logic [SLICE-1:0] b_dq [k];

      always_ff @(posedge clk) begin
        if (adv) begin
          a_dq[0] <= a_ext[EXT_W-1-k*SLICE -: SLICE];
          b_dq[0] <= b_ext[EXT_W-1-k*SLICE -: SLICE];
          for (int d = 1; d < k; d++) begin
            a_dq[d] <= a_dq[d-1];
            b_dq[d] <= b_dq[d-1];
          end
        end
      end

      assign a_sl[k] = a_dq[k-1];
      assign b_sl[k] = b_dq[k-1];

      cmp_slice_stage #(.SLICE(SLICE)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (adv),
        .vld_i (vld_s[k-1]),
        .dec_i (dec_s[k-1]),
        .a_i   (a_sl[k]),
        .b_i   (b_sl[k]),
        .vld_o (vld_s[k]),
        .dec_o (dec_s[k])
      );
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
    end else if (adv) begin
      out_vld_q <= vld_s[NUM_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      out_dec_q <= dec_s[NUM_STAGES-1];
    end
  end

  assign flags     = out_vld_q ? dec_to_flags(out_dec_q) : 3'b000;
  assign out_valid = out_vld_q;
  assign out_a     = flags[2];
  assign out_b     = flags[1];
  assign out_eq    = flags[0];

  always_comb begin
    eq_cnt_d = eq_cnt_q;
    if (eq_clear) begin
      eq_cnt_d = '0;
    end else if (out_vld_q && out_ready && out_eq && !(&eq_cnt_q)) begin
      eq_cnt_d = eq_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eq_cnt_q <= '0;
    end else begin
      eq_cnt_q <= eq_cnt_d;
    end
  end

  assign eq_count = eq_cnt_q;

endmodule

// File: doc/cmp_pipe.md
# cmp_pipe

Parametrised, pipelined magnitude comparator. It compares two WIDTH-bit operands slice by slice, MSB slice first, over NUM_STAGES register stages, so wide operands close timing. It supports unsigned and two's-complement signed comparison per transaction, uses valid/ready flow control on both sides, and keeps a saturating count of equal results. It replaces the single-cycle 2-bit combinational comparator wherever operands are wide or arrive as a stream.

## Interface
- WIDTH, 8: operand width in bits, ≥ 1.
- SLICE, 4: bits compared per pipeline stage, 1..WIDTH.
- NUM_STAGES (derived, not overridable): ceil(WIDTH/SLICE).
- CNT_W, 16: width of the equal-result counter.

- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned. Sampled with a and b.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_a  out  1  A > B.
- out_b  out  1  B > A.
- out_eq  out  1  A == B.
- eq_count  out  CNT_W  number of accepted results with out_eq=1. Saturates at all-ones.
- eq_clear  in  1  synchronous clear of eq_count.

## Operation
- Accept: a transfer happens when in_valid && in_ready. Output: a transfer happens when out_valid && out_ready.
- Slicing: if WIDTH is not a multiple of SLICE, operands are zero-extended at the MSB end (unsigned) or sign-extended (signed) to NUM_STAGES*SLICE bits. Slice 0 is the most significant slice.
- Signed mode: the top bit of the extended operands is inverted before comparison. After that, the compare is unsigned.
- Per-stage state: valid bit, 2-bit decision {UNDECIDED, A_GT, B_GT}, and the operand slices still to be compared.
- Stage k:
  - If the incoming decision is UNDECIDED, compare slice k: a>b gives A_GT, a<b gives B_GT, equal stays UNDECIDED.
  - A decided result passes through unchanged.
- Final stage: UNDECIDED maps to out_eq=1.
- Result flags: exactly one of out_a/out_b/out_eq is 1 while out_valid=1. All three are 0 while out_valid=0.
- Flow control: the whole pipeline advances as one. advance = !out_valid || out_ready, and in_ready = advance. Bubbles are not collapsed. An invalid stage shifts forward like any other.
- eq_count:
  - Increments on an output transfer with out_eq=1, unless already all-ones.
  - eq_clear has priority: clear and increment in the same cycle gives 0.
- Reset: rst_n=0 at a clock edge clears every stage valid bit and eq_count, and sets out_valid=0, out_a=out_b=out_eq=0. In-flight transactions are discarded and no partial result is emitted. in_ready is 1 in the first cycle after reset.

## Timing
- Latency: a pair accepted at edge n appears with out_valid=1 after edge n+NUM_STAGES, provided there are no stalls.
- Throughput: 1 pair/cycle while out_ready=1.
- Stall: with out_valid=1 && out_ready=0, all stages and outputs hold and in_ready=0 in that same cycle (combinational from out_ready).
- Decided results are never recomputed. Results leave in acceptance order.
- eq_count updates on the edge of the output transfer. It is visible the following cycle.

## Structure
- Package cmp_pipe_pkg:
  - decision enum (UNDECIDED=2'b00, A_GT=2'b01, B_GT=2'b10).
  - function to map a decision to {out_a, out_b, out_eq}.
- Sub-module cmp_slice_stage, one per stage via generate:
  - Ports: SLICE-bit slices, incoming decision, advance, valid in/out.
  - Contains one pipeline register.
- Top level: extension and sign inversion, handshake, eq counter.

## Test plan
- WIDTH=8, SLICE=4, signed_mode=0. Send a=0xA3, b=0xA7 → 2 cycles later out_b=1. Send a=0x5F, b=0x3F → out_a=1. Send a=b=0x42 → out_eq=1 and eq_count becomes 1.
- signed_mode=1, a=0x80 (−128), b=0x01 → out_b=1. The same operands with signed_mode=0 → out_a=1.
- Back-to-back stream of 16 pairs with out_ready=1 → 16 results on consecutive cycles, in order, each flag one-hot.
- Hold out_ready=0 for 5 cycles with a full pipe → in_ready=0, outputs stable. Release → no loss or duplication.
- CNT_W=2: four eq results → eq_count saturates at 3. eq_clear in the same cycle as an eq transfer → 0.
- Deassert rst_n mid-stream with the pipe full → next cycle out_valid=0, eq_count=0, in_ready=1, and no stale result appears afterwards. Also run WIDTH=7, SLICE=3 with signed a=0x40 (−64), b=0x3F → out_b=1.
